// File: rtl/i_stream_buffer_pkg.sv
// ----------------------------------------------------------------------------
// i_stream_buffer_pkg
//   Shared types and constants for the instruction stream buffer.
//   - sb_state_e       : controller states
//   - AxiIdWidth/Len   : AXI read-channel ID and burst-length field widths
//   - BytesPerWord     : bytes per data beat, used for line alignment
//   - line_offset_bits : number of byte-offset bits inside one cache line
// ----------------------------------------------------------------------------
package i_stream_buffer_pkg;

    localparam int unsigned AxiIdWidth   = 4;
    localparam int unsigned AxiLenWidth  = 4;
    localparam int unsigned BytesPerWord = 4;

    typedef enum logic [2:0] {
        StIdle,
        StHit,
        StDemandAr,
        StDemandR,
        StPfAr,
        StPfR
    } sb_state_e;

    function automatic int unsigned line_offset_bits(input int unsigned line_words);
        return $clog2(line_words * BytesPerWord);
    endfunction

endpackage

// File: rtl/i_stream_buffer_line_fifo.sv
// ----------------------------------------------------------------------------
// i_stream_buffer_line_fifo
//   DEPTH-entry FIFO of whole cache lines. Each entry holds a line tag, a
//   valid bit and LINE_WORDS data words. Words are written one at a time into
//   the tail entry; push then commits the tag and advances the tail. The head
//   entry's tag/valid are exposed for hit detection and any word of the head
//   line can be read combinationally.
// Ports
//   clk, rst_n  : clock, asynchronous active-low reset
//   flush       : invalidate every entry, pointers and count to zero
//   push        : commit tail entry with push_tag
//   pop         : retire head entry
//   wr_en       : write wr_data into word wr_word of the tail entry
//   rd_word     : word index read from the head entry onto rd_data
//   head_valid  : head entry holds a line
//   head_tag    : line address of the head entry
//   count       : number of committed lines
// ----------------------------------------------------------------------------
module i_stream_buffer_line_fifo
    import i_stream_buffer_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 26,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LINE_WORDS = 4,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           flush,
    input  logic                           push,
    input  logic [ADDR_WIDTH-1:0]          push_tag,
    input  logic                           pop,
    input  logic                           wr_en,
    input  logic [$clog2(LINE_WORDS)-1:0]  wr_word,
    input  logic [DATA_WIDTH-1:0]          wr_data,
    input  logic [$clog2(LINE_WORDS)-1:0]  rd_word,
    output logic                           head_valid,
    output logic [ADDR_WIDTH-1:0]          head_tag,
    output logic [DATA_WIDTH-1:0]          rd_data,
    output logic [$clog2(DEPTH+1)-1:0]     count
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH][LINE_WORDS];
    logic [ADDR_WIDTH-1:0] tag_q [DEPTH];
    logic [DEPTH-1:0]      valid_q;
    logic [PtrW-1:0]       head_q;
    logic [PtrW-1:0]       tail_q;
    logic [CntW-1:0]       count_q;

    // Line storage carries no reset; valid bits qualify its contents.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[tail_q][wr_word] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                tag_q[i] <= '0;
            end
        end else if (flush) begin
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                tag_q[tail_q]   <= push_tag;
                valid_q[tail_q] <= 1'b1;
                tail_q          <= tail_q + PtrW'(1);
            end
            if (pop) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + PtrW'(1);
            end
            count_q <= count_q + CntW'(push) - CntW'(pop);
        end
    end

    assign head_valid = valid_q[head_q];
    assign head_tag   = tag_q[head_q];
    assign rd_data    = mem_q[head_q][rd_word];
    assign count      = count_q;

endmodule

// File: rtl/i_stream_buffer.sv
// ----------------------------------------------------------------------------
// i_stream_buffer
//   Sequential instruction prefetcher between the I-cache miss port and a
//   memory read master. After a demand miss the buffer is flushed and then
//   refilled with the lines that follow the missed line. A demand whose line
//   matches the head entry is replayed from local storage without a memory
//   trip; anything else is forwarded to memory unchanged.
// Ports
//   clk, rst_n   : clock, asynchronous active-low reset
//   c_ar*        : read-address slave from the I-cache
//   c_r*         : read-data slave to the I-cache
//   m_ar*        : read-address master to the memory arbiter
//   m_r*         : read-data master from the memory arbiter
//   o_hit        : one-cycle pulse when a demand is accepted as a head hit
// ----------------------------------------------------------------------------
module i_stream_buffer
    import i_stream_buffer_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH = 26,
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           LINE_WORDS = 4,
    parameter int unsigned           DEPTH      = 4,
    parameter logic [AxiIdWidth-1:0] PF_ID      = 4'hE
) (
    input  logic                   clk,
    input  logic                   rst_n,
    // I-cache read address
    input  logic                   c_arvalid,
    output logic                   c_arready,
    input  logic [AxiIdWidth-1:0]  c_arid,
    input  logic [AxiLenWidth-1:0] c_arlen,
    input  logic [ADDR_WIDTH-1:0]  c_araddr,
    // I-cache read data
    output logic                   c_rvalid,
    input  logic                   c_rready,
    output logic                   c_rlast,
    output logic [AxiIdWidth-1:0]  c_rid,
    output logic [DATA_WIDTH-1:0]  c_rdata,
    // Memory read address
    output logic                   m_arvalid,
    input  logic                   m_arready,
    output logic [AxiIdWidth-1:0]  m_arid,
    output logic [AxiLenWidth-1:0] m_arlen,
    output logic [ADDR_WIDTH-1:0]  m_araddr,
    // Memory read data
    input  logic                   m_rvalid,
    output logic                   m_rready,
    input  logic                   m_rlast,
    input  logic [AxiIdWidth-1:0]  m_rid,
    input  logic [DATA_WIDTH-1:0]  m_rdata,
    output logic                   o_hit
);

    localparam int unsigned OffW  = line_offset_bits(LINE_WORDS);
    localparam int unsigned WordW = $clog2(LINE_WORDS);
    localparam int unsigned CntW  = $clog2(DEPTH + 1);

    localparam logic [ADDR_WIDTH-1:0]  OffMask   = ADDR_WIDTH'((1 << OffW) - 1);
    localparam logic [ADDR_WIDTH-1:0]  LineBytes = ADDR_WIDTH'(LINE_WORDS * BytesPerWord);
    localparam logic [WordW-1:0]       LastBeat  = WordW'(LINE_WORDS - 1);
    localparam logic [AxiLenWidth-1:0] PfLen     = AxiLenWidth'(LINE_WORDS - 1);
    localparam logic [CntW-1:0]        FullCount = CntW'(DEPTH);

    sb_state_e              state_q;
    logic [AxiIdWidth-1:0]  req_id_q;
    logic [AxiLenWidth-1:0] req_len_q;
    logic [ADDR_WIDTH-1:0]  req_addr_q;
    logic [ADDR_WIDTH-1:0]  pf_next_q;
    logic                   pf_valid_q;
    logic [WordW-1:0]       beat_q;

    logic                   head_valid;
    logic [ADDR_WIDTH-1:0]  head_tag;
    logic [DATA_WIDTH-1:0]  head_rdata;
    logic [CntW-1:0]        count;

    logic [ADDR_WIDTH-1:0]  c_line;
    logic                   accept;
    logic                   head_hit;
    logic                   fifo_flush;
    logic                   fifo_push;
    logic                   fifo_pop;
    logic                   fifo_wr;

    assign c_line = c_araddr & ~OffMask;

    // Control strobes shared by the FSM and the line FIFO.
    always_comb begin
        // Gating with rst_n keeps the accept path quiet while reset is held.
        accept     = rst_n && (state_q == StIdle) && c_arvalid;
        head_hit   = head_valid && (head_tag == c_line);
        fifo_flush = accept && !head_hit;
        fifo_pop   = (state_q == StHit) && c_rready && (beat_q == LastBeat);
        fifo_wr    = (state_q == StPfR) && m_rvalid;
        // Memory RLAST alone ends a prefetch burst.
        fifo_push  = fifo_wr && m_rlast;
    end

    always_comb begin
        c_arready = accept;
        o_hit     = accept && head_hit;
        c_rvalid  = 1'b0;
        c_rlast   = 1'b0;
        c_rid     = req_id_q;
        c_rdata   = head_rdata;
        m_arvalid = 1'b0;
        m_arid    = req_id_q;
        m_arlen   = req_len_q;
        m_araddr  = req_addr_q;
        m_rready  = 1'b0;
        case (state_q)
            StHit: begin
                c_rvalid = 1'b1;
                c_rlast  = (beat_q == LastBeat);
            end
            StDemandAr: begin
                m_arvalid = 1'b1;
            end
            StDemandR: begin
                // Zero-latency pass-through of the demand burst.
                c_rvalid = m_rvalid;
                c_rlast  = m_rlast;
                c_rid    = m_rid;
                c_rdata  = m_rdata;
                m_rready = c_rready;
            end
            StPfAr: begin
                m_arvalid = 1'b1;
                m_arid    = PF_ID;
                m_arlen   = PfLen;
                m_araddr  = pf_next_q;
            end
            StPfR: begin
                m_rready = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            req_id_q   <= '0;
            req_len_q  <= '0;
            req_addr_q <= '0;
            pf_next_q  <= '0;
            pf_valid_q <= 1'b0;
            beat_q     <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    // Demand always outranks a prefetch.
                    if (accept) begin
                        req_id_q   <= c_arid;
                        req_len_q  <= c_arlen;
                        req_addr_q <= c_araddr;
                        beat_q     <= '0;
                        if (head_hit) begin
                            state_q <= StHit;
                        end else begin
                            pf_next_q  <= c_line + LineBytes;
                            pf_valid_q <= 1'b1;
                            state_q    <= StDemandAr;
                        end
                    end else if (pf_valid_q && (count < FullCount)) begin
                        state_q <= StPfAr;
                    end
                end
                StHit: begin
                    if (c_rready) begin
                        beat_q <= beat_q + WordW'(1);
                        if (beat_q == LastBeat) begin
                            state_q <= StIdle;
                        end
                    end
                end
                StDemandAr: begin
                    if (m_arready) begin
                        state_q <= StDemandR;
                    end
                end
                StDemandR: begin
                    if (m_rvalid && c_rready && m_rlast) begin
                        state_q <= StIdle;
                    end
                end
                StPfAr: begin
                    // Once raised, m_arvalid is held until the handshake.
                    if (m_arready) begin
                        beat_q  <= '0;
                        state_q <= StPfR;
                    end
                end
                StPfR: begin
                    if (m_rvalid) begin
                        beat_q <= beat_q + WordW'(1);
                        if (m_rlast) begin
                            pf_next_q <= pf_next_q + LineBytes;
                            beat_q    <= '0;
                            state_q   <= StIdle;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    i_stream_buffer_line_fifo #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH),
        .LINE_WORDS(LINE_WORDS),
        .DEPTH     (DEPTH)
    ) u_line_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (fifo_flush),
        .push      (fifo_push),
        .push_tag  (pf_next_q),
        .pop       (fifo_pop),
        .wr_en     (fifo_wr),
        .wr_word   (beat_q),
        .wr_data   (m_rdata),
        .rd_word   (beat_q),
        .head_valid(head_valid),
        .head_tag  (head_tag),
        .rd_data   (head_rdata),
        .count     (count)
    );

endmodule

// File: tb/tb_i_stream_buffer.sv
module tb_i_stream_buffer;

    localparam int unsigned AW    = 26;
    localparam int unsigned DW    = 32;
    localparam int unsigned LW    = 4;
    localparam int unsigned DEPTH = 4;

    logic          clk;
    logic          rst_n;
    logic          c_arvalid, c_arready;
    logic [3:0]    c_arid, c_arlen;
    logic [AW-1:0] c_araddr;
    logic          c_rvalid, c_rready, c_rlast;
    logic [3:0]    c_rid;
    logic [DW-1:0] c_rdata;
    logic          m_arvalid, m_arready;
    logic [3:0]    m_arid, m_arlen;
    logic [AW-1:0] m_araddr;
    logic          m_rvalid, m_rready, m_rlast;
    logic [3:0]    m_rid;
    logic [DW-1:0] m_rdata;
    logic          o_hit;

    int n_cmp  = 0;
    int n_fail = 0;

    // Memory-side bookkeeping.
    logic [63:0] ar_log[$];
    bit          slave_busy  = 0;
    int          bursts_done = 0;

    // Reference model: lines the buffer will hold once it has refilled.
    logic [AW-1:0] mq[$];
    logic [AW-1:0] m_next;
    logic [63:0]   exp_ar[$];

    i_stream_buffer #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .LINE_WORDS(LW),
        .DEPTH     (DEPTH),
        .PF_ID     (4'hE)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .c_arvalid(c_arvalid),
        .c_arready(c_arready),
        .c_arid   (c_arid),
        .c_arlen  (c_arlen),
        .c_araddr (c_araddr),
        .c_rvalid (c_rvalid),
        .c_rready (c_rready),
        .c_rlast  (c_rlast),
        .c_rid    (c_rid),
        .c_rdata  (c_rdata),
        .m_arvalid(m_arvalid),
        .m_arready(m_arready),
        .m_arid   (m_arid),
        .m_arlen  (m_arlen),
        .m_araddr (m_araddr),
        .m_rvalid (m_rvalid),
        .m_rready (m_rready),
        .m_rlast  (m_rlast),
        .m_rid    (m_rid),
        .m_rdata  (m_rdata),
        .o_hit    (o_hit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
        logic [31:0] x;
        x = {6'd0, a};
        return (x * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Memory slave: one burst at a time, random address and data stalls.
    initial begin : mem_slave
        logic [AW-1:0] a;
        logic [3:0]    id, len;
        bit            hs;
        int            guard;
        m_arready = 0; m_rvalid = 0; m_rlast = 0; m_rid = 0; m_rdata = 0;
        forever begin
            @(posedge clk); #1;
            if (rst_n && m_arvalid) begin
                slave_busy = 1;
                a = m_araddr; id = m_arid; len = m_arlen;
                ar_log.push_back({30'd0, id, len, a});
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                m_arready = 1;
                @(posedge clk); #1;
                m_arready = 0;
                for (int i = 0; i <= int'(len); i++) begin
                    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                    m_rvalid = 1;
                    m_rdata  = mem_word(a + AW'(4 * i));
                    m_rid    = id;
                    m_rlast  = (i == int'(len));
                    guard    = 0;
                    do begin
                        @(negedge clk); hs = m_rready;
                        @(posedge clk); #1;
                        guard++;
                    end while (!hs && guard < 1000);
                    if (!hs) begin
                        $display("FAIL slave_rready_timeout: observed 0 expected 1");
                        $fatal(1, "memory slave stalled");
                    end
                    m_rvalid = 0;
                    m_rlast  = 0;
                end
                bursts_done++;
                slave_busy = 0;
            end
        end
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic model_demand(input logic [AW-1:0] addr, input logic [3:0] id,
                                output bit hit);
        logic [AW-1:0] line;
        line = addr & ~AW'(LW * 4 - 1);
        if (mq.size() > 0 && mq[0] == line) begin
            hit = 1;
            void'(mq.pop_front());
        end else begin
            hit = 0;
            mq.delete();
            exp_ar.push_back({30'd0, id, 4'(LW - 1), addr});
            m_next = line + AW'(LW * 4);
        end
        while (mq.size() < DEPTH) begin
            exp_ar.push_back({30'd0, 4'hE, 4'(LW - 1), m_next});
            mq.push_back(m_next);
            m_next = m_next + AW'(LW * 4);
        end
    endtask

    task automatic issue(input logic [AW-1:0] addr, input logic [3:0] id,
                         output bit hit, output int bd_at_acc);
        int guard;
        bit acc;
        guard = 0; acc = 0; hit = 0; bd_at_acc = -1;
        c_arvalid = 1; c_araddr = addr; c_arid = id; c_arlen = 4'(LW - 1);
        while (!acc && guard < 600) begin
            @(negedge clk);
            if (c_arready) begin
                acc = 1; hit = o_hit; bd_at_acc = bursts_done;
            end
            @(posedge clk); #1;
            guard++;
        end
        c_arvalid = 0;
        chk("accept", acc, 1);
    endtask

    task automatic recv(input logic [AW-1:0] base, input logic [3:0] id, input bit hit_mode);
        int got, guard, arv_bad;
        got = 0; guard = 0; arv_bad = 0;
        while (got < LW && guard < 600) begin
            c_rready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (hit_mode && m_arvalid) arv_bad++;
            if (c_rvalid && c_rready) begin
                chk("rdata", c_rdata, mem_word(base + AW'(4 * got)));
                chk("rid", c_rid, id);
                chk("rlast", c_rlast, (got == LW - 1));
                got++;
            end
            @(posedge clk); #1;
            guard++;
        end
        c_rready = 0;
        chk("beats", got, LW);
        if (hit_mode) chk("no_m_ar_in_replay", arv_bad, 0);
    endtask

    task automatic settle();
        int guard;
        guard = 0;
        while ((ar_log.size() < exp_ar.size() || slave_busy) && guard < 3000) begin
            @(posedge clk); #1;
            guard++;
        end
        repeat (8) begin @(posedge clk); #1; end
        chk("ar_count", ar_log.size(), exp_ar.size());
        while (ar_log.size() > 0 && exp_ar.size() > 0) begin
            chk("ar_req", ar_log.pop_front(), exp_ar.pop_front());
        end
        ar_log.delete();
        exp_ar.delete();
    endtask

    task automatic step(input logic [AW-1:0] addr, input logic [3:0] id);
        bit eh, h;
        int bd;
        logic [AW-1:0] base;
        model_demand(addr, id, eh);
        issue(addr, id, h, bd);
        chk("hit", h, eh);
        base = eh ? (addr & ~AW'(LW * 4 - 1)) : addr;
        recv(base, id, eh);
        settle();
    endtask

    initial begin : main
        bit            h, eh, seen;
        int            bd0, bd, guard;
        logic [AW-1:0] addr, line;

        rst_n = 0; c_arvalid = 0; c_arid = 0; c_arlen = 0; c_araddr = 0; c_rready = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_c_arready", c_arready, 0);
        chk("rst_c_rvalid", c_rvalid, 0);
        chk("rst_m_arvalid", m_arvalid, 0);
        chk("rst_m_rready", m_rready, 0);
        chk("rst_o_hit", o_hit, 0);
        rst_n = 1;
        repeat (6) begin @(posedge clk); #1; end
        chk("idle_no_prefetch", ar_log.size(), 0);

        // Cold miss, then four prefetches fill the buffer.
        step(26'h000100, 4'h5);
        // Head hit replays locally, one more prefetch follows.
        step(26'h000110, 4'h6);
        // Miss on a non-head line flushes and restarts the stream.
        step(26'h000200, 4'h7);

        // Demand for the line currently being prefetched waits for the burst.
        step(26'h000300, 4'h1);
        model_demand(26'h000300, 4'h1, eh);
        issue(26'h000300, 4'h1, h, bd);
        chk("t4_first_miss", h, 0);
        recv(26'h000300, 4'h1, 0);
        seen = 0; guard = 0;
        while (!seen && guard < 200) begin
            @(negedge clk); seen = m_arvalid;
            @(posedge clk); #1;
            guard++;
        end
        chk("t4_pf_started", seen, 1);
        bd0 = bursts_done;
        model_demand(26'h000310, 4'h2, eh);
        issue(26'h000310, 4'h2, h, bd);
        chk("t4_model_hit", eh, 1);
        chk("t4_hit", h, 1);
        chk("t4_held_until_rlast", bd, bd0 + 1);
        recv(26'h000310, 4'h2, 1);
        settle();

        // Line stream wraps past the top of the address space.
        step(26'h3FFFFF4, 4'h3);
        step(26'h0000008, 4'h4);

        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 3))
                0, 1: addr = mq[0] + AW'(4 * $urandom_range(0, 3));
                2: addr = AW'(16 * $urandom_range(0, 1023)) + AW'(4 * $urandom_range(0, 3));
                default: addr = 26'h3FFFFC0 + AW'(16 * $urandom_range(0, 3));
            endcase
            step(addr, 4'($urandom_range(0, 13)));
        end

        // Reset in the middle of a hit replay.
        line = mq[0];
        issue(line, 4'h9, h, bd);
        chk("t6_hit", h, 1);
        c_rready = 1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 0;
        #1;
        chk("t6_c_rvalid", c_rvalid, 0);
        chk("t6_c_arready", c_arready, 0);
        chk("t6_m_arvalid", m_arvalid, 0);
        chk("t6_m_rready", m_rready, 0);
        chk("t6_o_hit", o_hit, 0);
        c_rready = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
        mq.delete();
        exp_ar.delete();
        ar_log.delete();
        repeat (10) begin @(posedge clk); #1; end
        chk("t6_no_pf_after_reset", ar_log.size(), 0);
        step(line, 4'hA);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
